// File: rtl/frame_color_locator.sv
// frame_color_locator
// Watches the pixel stream leaving the display path and, once per frame,
// publishes the bounding box, centre and pixel count of every visible pixel
// matching MATCH_COLOR under MATCH_MASK, in the signed display plane
// x = hcount - TOTAL_WIDTH/2, y = TOTAL_HEIGHT - vcount.
//
// Ports
//   vclock, reset            pixel clock, synchronous active-high reset
//   hcount, vcount           raster position of the current pixel
//   vsync (active low), blank, pixel
//   result_ack               consumer has taken the published results
//   result_valid             results held and not yet acknowledged
//   found, box_*, center_*   published region (zero when nothing matched)
//   match_count              saturating matching-pixel count
//   frame_count              publishes so far, wraps
//   overrun                  sticky: a publish overwrote unacknowledged results
//
// state   | meaning
// SYNC    | after reset; partial frame discarded, accumulators held clear
// ACCUM   | accumulating matches of the current frame
// DRAIN   | two cycles letting in-flight matches reach the accumulators
// PUBLISH | load outputs, clear accumulators, back to ACCUM
module frame_color_locator #(
   parameter logic [23:0] MATCH_COLOR  = 24'h00_FF_00,
   parameter logic [23:0] MATCH_MASK   = 24'hFF_FF_FF,
   parameter int          TOTAL_WIDTH  = 1024,
   parameter int          TOTAL_HEIGHT = 768,
   parameter int          COUNT_WIDTH  = 20
) (
   input  logic                    vclock,
   input  logic                    reset,
   input  logic [10:0]             hcount,
   input  logic [9:0]              vcount,
   input  logic                    vsync,
   input  logic                    blank,
   input  logic [23:0]             pixel,
   input  logic                    result_ack,
   output logic                    result_valid,
   output logic                    found,
   output logic signed [11:0]      box_left,
   output logic signed [11:0]      box_right,
   output logic signed [11:0]      box_bottom,
   output logic signed [11:0]      box_top,
   output logic signed [11:0]      center_x,
   output logic signed [11:0]      center_y,
   output logic [COUNT_WIDTH-1:0]  match_count,
   output logic [7:0]              frame_count,
   output logic                    overrun
);

   localparam logic [11:0] HALF_W = 12'(TOTAL_WIDTH / 2);
   localparam logic [11:0] HEIGHT = 12'(TOTAL_HEIGHT);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {SYNC, ACCUM, DRAIN, PUBLISH} state_t;

   state_t state_q;
   logic   drain_cnt_q;

   logic                   match_d, match_q, vsync_q;
   logic signed [11:0]     x_d, y_d, x_q, y_q;

   logic                   acc_found_q;
   logic signed [11:0]     acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
   logic [COUNT_WIDTH-1:0] acc_cnt_q;

   logic                   result_valid_q, found_q, overrun_q;
   logic signed [11:0]     box_left_q, box_right_q, box_bottom_q, box_top_q;
   logic signed [11:0]     center_x_q, center_y_q;
   logic [COUNT_WIDTH-1:0] match_count_q;
   logic [7:0]             frame_count_q;

   logic                   frame_end, acc_en, acc_clr;
   logic signed [12:0]     sum_x_d, sum_y_d;

   assign match_d   = ((pixel & MATCH_MASK) == (MATCH_COLOR & MATCH_MASK)) && !blank;
   assign x_d       = {1'b0, hcount} - HALF_W;
   assign y_d       = HEIGHT - {2'b0, vcount};
   assign frame_end = vsync_q && !vsync;

   assign acc_en  = match_q && ((state_q == ACCUM) || (state_q == DRAIN));
   assign acc_clr = (state_q == SYNC) || (state_q == PUBLISH);

   // Sign-extend into 13 bits so the sum cannot overflow; dropping bit 0 of
   // the signed sum is an arithmetic shift, i.e. floor for negative centres.
   assign sum_x_d = {acc_xmin_q[11], acc_xmin_q} + {acc_xmax_q[11], acc_xmax_q};
   assign sum_y_d = {acc_ymin_q[11], acc_ymin_q} + {acc_ymax_q[11], acc_ymax_q};

   always_ff @(posedge vclock) begin
      if (reset) begin
         match_q <= 1'b0;
         vsync_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         match_q <= match_d;
         vsync_q <= vsync;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_ff @(posedge vclock) begin
      if (reset || acc_clr) begin
         acc_found_q <= 1'b0;
         acc_xmin_q  <= '0;
         acc_xmax_q  <= '0;
         acc_ymin_q  <= '0;
         acc_ymax_q  <= '0;
         acc_cnt_q   <= '0;
      end else if (acc_en) begin
         acc_found_q <= 1'b1;
         if (!acc_found_q || x_q < acc_xmin_q) acc_xmin_q <= x_q;
         if (!acc_found_q || x_q > acc_xmax_q) acc_xmax_q <= x_q;
         if (!acc_found_q || y_q < acc_ymin_q) acc_ymin_q <= y_q;
         if (!acc_found_q || y_q > acc_ymax_q) acc_ymax_q <= y_q;
         if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge vclock) begin
      if (reset) begin
         state_q        <= SYNC;
         drain_cnt_q    <= 1'b0;
         result_valid_q <= 1'b0;
         found_q        <= 1'b0;
         overrun_q      <= 1'b0;
         box_left_q     <= '0;
         box_right_q    <= '0;
         box_bottom_q   <= '0;
         box_top_q      <= '0;
         center_x_q     <= '0;
         center_y_q     <= '0;
         match_count_q  <= '0;
         frame_count_q  <= '0;
      end else begin
         if (state_q != PUBLISH && result_ack) result_valid_q <= 1'b0;
         unique case (state_q)
            SYNC: begin
               if (frame_end) state_q <= ACCUM;
            end
            ACCUM: begin
               if (frame_end) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt_q == 1'b0) state_q <= PUBLISH;
               else                     drain_cnt_q <= drain_cnt_q - 1'b1;
            end
            PUBLISH: begin
               state_q        <= ACCUM;
               result_valid_q <= 1'b1;
               frame_count_q  <= frame_count_q + 8'd1;
               if (result_valid_q && !result_ack) overrun_q <= 1'b1;
               found_q        <= acc_found_q;
               match_count_q  <= acc_cnt_q;
               if (acc_found_q) begin
                  box_left_q   <= acc_xmin_q;
                  box_right_q  <= acc_xmax_q;
                  box_bottom_q <= acc_ymin_q;
                  box_top_q    <= acc_ymax_q;
                  center_x_q   <= sum_x_d[12:1];
                  center_y_q   <= sum_y_d[12:1];
               end else begin
                  box_left_q   <= '0;
                  box_right_q  <= '0;
                  box_bottom_q <= '0;
                  box_top_q    <= '0;
                  center_x_q   <= '0;
                  center_y_q   <= '0;
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end

   assign result_valid = result_valid_q;
   assign found        = found_q;
   assign overrun      = overrun_q;
   assign box_left     = box_left_q;
   assign box_right    = box_right_q;
   assign box_bottom   = box_bottom_q;
   assign box_top      = box_top_q;
   assign center_x     = center_x_q;
   assign center_y     = center_y_q;
   assign match_count  = match_count_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_frame_color_locator.sv
module tb_frame_color_locator;

   logic        vclock = 1'b0;
   logic        reset, vsync, blank, result_ack;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [23:0] pixel;

   always #5 vclock = ~vclock;

   // a: defaults, b: green-only mask, c: 8-bit count
   logic              a_valid, a_found, a_ovr, b_valid, b_found, b_ovr, c_valid, c_found, c_ovr;
   logic signed [11:0] a_l, a_r, a_b, a_t, a_cx, a_cy;
   logic signed [11:0] b_l, b_r, b_b, b_t, b_cx, b_cy;
   logic signed [11:0] c_l, c_r, c_b, c_t, c_cx, c_cy;
   logic [19:0]       a_cnt, b_cnt;
   logic [7:0]        c_cnt, a_fc, b_fc, c_fc;

   frame_color_locator u_a (
      .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
      .blank(blank), .pixel(pixel), .result_ack(result_ack), .result_valid(a_valid),
      .found(a_found), .box_left(a_l), .box_right(a_r), .box_bottom(a_b), .box_top(a_t),
      .center_x(a_cx), .center_y(a_cy), .match_count(a_cnt), .frame_count(a_fc), .overrun(a_ovr));

   frame_color_locator #(.MATCH_MASK(24'h00_FF_00)) u_b (
      .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
      .blank(blank), .pixel(pixel), .result_ack(result_ack), .result_valid(b_valid),
      .found(b_found), .box_left(b_l), .box_right(b_r), .box_bottom(b_b), .box_top(b_t),
      .center_x(b_cx), .center_y(b_cy), .match_count(b_cnt), .frame_count(b_fc), .overrun(b_ovr));

   frame_color_locator #(.COUNT_WIDTH(8)) u_c (
      .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
      .blank(blank), .pixel(pixel), .result_ack(result_ack), .result_valid(c_valid),
      .found(c_found), .box_left(c_l), .box_right(c_r), .box_bottom(c_b), .box_top(c_t),
      .center_x(c_cx), .center_y(c_cy), .match_count(c_cnt), .frame_count(c_fc), .overrun(c_ovr));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic draw_rect(input int h0, input int v0, input int w, input int hh,
                            input logic [23:0] col, input logic blk);
      for (int v = v0; v < v0 + hh; v++)
         for (int h = h0; h < h0 + w; h++) begin
            @(negedge vclock);
            hcount = 11'(h);
            vcount = 10'(v);
            pixel  = col;
            blank  = blk;
         end
   endtask

   // vsync low at n0; PUBLISH is sampled on the third negedge after n0's edge,
   // so raising ack at the third loop negedge lands it on the PUBLISH cycle.
   task automatic end_frame(input bit ack_pub);
      @(negedge vclock);
      vsync = 1'b0; blank = 1'b1; pixel = '0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge vclock);
         result_ack = (ack_pub && i == 3);
      end
      @(negedge vclock);
      vsync = 1'b1;
      @(negedge vclock);
   endtask

   task automatic ack_pulse();
      @(negedge vclock);
      result_ack = 1'b1;
      @(negedge vclock);
      result_ack = 1'b0;
   endtask

   typedef struct {
      int h0, v0, w, hh;
      logic [23:0] col;
      int fnd, l, r, b, t, cx, cy, cnt, fc;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{596, 553, 32, 32, 24'h00FF00, 1,   84,  115, 184, 215,   99, 199, 1024, 1};
      vecs[1] = '{0,   0,   0,  0,  24'h000000, 0,    0,    0,   0,   0,    0,   0,    0, 2};
      vecs[2] = '{0,   700, 2,  3,  24'h00FF00, 1, -512, -511,  66,  68, -512,  67,    6, 3};
      vecs[3] = '{1000, 10, 1,  1,  24'h00FF00, 1,  488,  488, 758, 758,  488, 758,    1, 4};

      reset = 1'b1; vsync = 1'b1; blank = 1'b1; result_ack = 1'b0;
      hcount = '0; vcount = '0; pixel = '0;
      repeat (3) @(negedge vclock);
      reset = 1'b0;
      @(negedge vclock);
      chk("reset valid", a_valid, 0);
      chk("reset found", a_found, 0);
      chk("reset overrun", a_ovr, 0);
      chk("reset box_left", a_l, 0);
      chk("reset count", a_cnt, 0);
      chk("reset frame_count", a_fc, 0);

      // partial first frame after reset is never published
      draw_rect(596, 553, 4, 4, 24'h00FF00, 1'b0);
      end_frame(0);
      chk("sync no publish valid", a_valid, 0);
      chk("sync no publish fc", a_fc, 0);

      foreach (vecs[i]) begin
         ack_pulse();
         if (vecs[i].w > 0) draw_rect(vecs[i].h0, vecs[i].v0, vecs[i].w, vecs[i].hh, vecs[i].col, 1'b0);
         end_frame(0);
         chk($sformatf("v%0d valid", i), a_valid, 1);
         chk($sformatf("v%0d found", i), a_found, vecs[i].fnd);
         chk($sformatf("v%0d left", i), a_l, vecs[i].l);
         chk($sformatf("v%0d right", i), a_r, vecs[i].r);
         chk($sformatf("v%0d bottom", i), a_b, vecs[i].b);
         chk($sformatf("v%0d top", i), a_t, vecs[i].t);
         chk($sformatf("v%0d cx", i), a_cx, vecs[i].cx);
         chk($sformatf("v%0d cy", i), a_cy, vecs[i].cy);
         chk($sformatf("v%0d count", i), a_cnt, vecs[i].cnt);
         chk($sformatf("v%0d fc", i), a_fc, vecs[i].fc);
         chk($sformatf("v%0d overrun", i), a_ovr, 0);
      end

      // acked: valid must drop
      ack_pulse();
      chk("ack clears valid", a_valid, 0);
      chk("data stable after ack", a_l, 488);

      // yellow square: only the green-only mask sees it
      draw_rect(100, 100, 16, 16, 24'hFFFF00, 1'b0);
      end_frame(0);
      chk("yellow default found", a_found, 0);
      chk("yellow default count", a_cnt, 0);
      chk("yellow mask found", b_found, 1);
      chk("yellow mask count", b_cnt, 256);
      chk("yellow mask left", b_l, -412);
      chk("yellow mask bottom", b_b, 653);
      chk("yellow fc", a_fc, 5);

      // 300 matches plus a green pixel under blank far to the right
      ack_pulse();
      draw_rect(300, 300, 20, 15, 24'h00FF00, 1'b0);
      draw_rect(1200, 10, 1, 1, 24'h00FF00, 1'b1);
      end_frame(0);
      chk("300 count", a_cnt, 300);
      chk("sat count 8b", c_cnt, 255);
      chk("blank not counted right", a_r, -193);
      chk("300 top", a_t, 468);

      // valid still 1 from above; ack lands on PUBLISH: new data, no overrun
      draw_rect(600, 400, 1, 1, 24'h00FF00, 1'b0);
      end_frame(1);
      chk("ack@pub valid", a_valid, 1);
      chk("ack@pub overrun", a_ovr, 0);
      chk("ack@pub left", a_l, 88);
      @(negedge vclock);
      chk("ack@pub valid held", a_valid, 1);

      // second unacknowledged publish
      draw_rect(610, 410, 1, 1, 24'h00FF00, 1'b0);
      end_frame(0);
      chk("overrun set", a_ovr, 1);
      chk("overrun left", a_l, 98);
      chk("overrun top", a_t, 358);
      chk("overrun fc", a_fc, 8);

      // reset mid-frame: the square after reset must not be published
      ack_pulse();
      draw_rect(200, 200, 4, 4, 24'h00FF00, 1'b0);
      @(negedge vclock); reset = 1'b1;
      @(negedge vclock); @(negedge vclock); reset = 1'b0;
      draw_rect(596, 553, 32, 32, 24'h00FF00, 1'b0);
      end_frame(0);
      chk("post-reset no publish", a_valid, 0);
      chk("post-reset fc", a_fc, 0);
      chk("post-reset overrun", a_ovr, 0);
      draw_rect(596, 553, 32, 32, 24'h00FF00, 1'b0);
      end_frame(0);
      chk("post-reset valid", a_valid, 1);
      chk("post-reset fc1", a_fc, 1);
      chk("post-reset left", a_l, 84);
      chk("post-reset right", a_r, 115);
      chk("post-reset bottom", a_b, 184);
      chk("post-reset top", a_t, 215);
      chk("post-reset count", a_cnt, 1024);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_color_locator.md
# frame_color_locator

Reads the 24-bit pixel stream leaving the VGA display path, together with its hcount/vcount/vsync/blank, on the 65 MHz vclock. It finds every visible pixel that matches a programmable colour. Once per frame it publishes the matching region as a bounding box, centre and pixel count, all in the display's signed (x,y) plane. Downstream logic uses these results to confirm where the rover and target were actually drawn, closing the loop on the display writer.

## Interface
Parameters:
- MATCH_COLOR, 24'h00_FF_00: colour to detect (r=23:16, g=15:8, b=7:0).
- MATCH_MASK, 24'hFF_FF_FF: bits that take part in the compare.
- TOTAL_WIDTH, 1024: used for x = hcount − TOTAL_WIDTH/2.
- TOTAL_HEIGHT, 768: used for y = TOTAL_HEIGHT − vcount.
- COUNT_WIDTH, 20: width of match_count.

Ports:
- vclock  in  1  65 MHz pixel clock.
- reset  in  1  reset, synchronous, active-high.
- hcount  in  11  horizontal pixel index.
- vcount  in  10  vertical pixel index.
- vsync  in  1  vertical sync, active low.
- blank  in  1  1 = pixel not visible.
- pixel  in  24  pixel being displayed.
- result_ack  in  1  consumer has taken the current results.
- result_valid  out  1  results are held and unacknowledged.
- found  out  1  at least one match in the published frame.
- box_left, box_right  out  12 signed  minimum/maximum matching x.
- box_bottom, box_top  out  12 signed  minimum/maximum matching y.
- center_x, center_y  out  12 signed  bounding-box centre.
- match_count  out  COUNT_WIDTH  number of matching pixels, saturating.
- frame_count  out  8  frames published, wraps 255→0.
- overrun  out  1  sticky: a publish occurred while result_valid was still 1.

## Operation
Match rule: (pixel & MATCH_MASK) == (MATCH_COLOR & MATCH_MASK) && !blank.

Pipeline:
- Stage 1 registers the match bit, signed 12-bit x and y, and a delayed copy of vsync.
- Stage 2 updates the accumulators on a registered match:
  - first match of the frame loads min=max=x/y;
  - later matches extend min/max;
  - count increments and saturates at all-ones.

Frame end is the falling edge of vsync: registered vsync_q=1 and current vsync=0.

State machine:
- SYNC: after reset. Accumulators are held clear, the partial frame is discarded. Goes to ACCUM on the first vsync falling edge.
- ACCUM: accumulates pixels. Goes to DRAIN on a vsync falling edge.
- DRAIN: 2 cycles to flush the pipeline; matches still in flight are accumulated. Then PUBLISH.
- PUBLISH: 1 cycle. Registers all result outputs, clears the accumulators, then returns to ACCUM.
  - Sets result_valid=1.
  - Increments frame_count.
  - If result_valid was already 1 and result_ack is 0 on this cycle, sets overrun=1.

Arithmetic:
- center_x = (box_left + box_right) >>> 1, with a 13-bit intermediate and arithmetic shift (floor).
- center_y is computed the same way from box_bottom and box_top.

No-match frame: found=0; box, center and match_count are published as 0; result_valid still pulses high.

Handshake:
- result_valid stays high until the cycle after result_ack=1 is sampled.
- If ack and PUBLISH occur in the same cycle, publish wins: result_valid stays 1, new data is loaded, and no overrun is raised.

## Timing
- Reset values:
  - result_valid, found, overrun: 0.
  - All box/center outputs, match_count, frame_count: 0.
  - State: SYNC.
- Reset mid-frame aborts accumulation. The first frame after reset is never published; the first publish follows the second vsync falling edge.
- Match latency: 2 edges from pixel input to accumulator update.
- Publish latency: if vsync is first sampled low at edge T, DRAIN occupies T+1 and T+2, PUBLISH is T+3, and outputs and result_valid are visible after edge T+3.
- Results stay stable until the next PUBLISH, whether or not they have been acknowledged.

## Test plan
- Green 32×32 square at hcount 596..627, vcount 553..584 on a black frame → box 84/115/184/215, center (99,199), match_count 1024, found=1, frame_count +1.
- All-black frame → found=0, box/center/count all 0, result_valid=1.
- MATCH_MASK=24'h00_FF_00 with a yellow FF_FF_00 square of 16×16 → match_count 256. With the default mask the same frame gives found=0.
- No result_ack for 2 frames → overrun=1 after the second publish and data = second frame. Ack on the exact PUBLISH cycle → result_valid stays 1, no overrun.
- Reset asserted mid-frame, with the square drawn in the half after reset → no publish at that frame's end. The next full frame publishes the correct box with frame_count=1.
- COUNT_WIDTH=8 with 300 matching pixels → match_count=255. A match at blank=1 is not counted. A match at hcount 0 (x=−512) → box_left=−512.
